data_bus_bridge: RTL and testbench
==================================

// Module: data_bus_bridge
// PURPOSE
//  Sits between the processor's data port and the data-side RAM / board I/O, downstream of the processor.
//  Decodes DataAddr, drives a synchronous RAM (fixed read latency) and memory-mapped LEDR/HEX/SW/KEY.
//  Generates DataWaitreq so the processor stalls until read data is valid; writes complete in one cycle.
// PARAMETERS
//  READ_LATENCY  1   RAM clock edges from address to valid mem_rdata (legal range: 1..4)
//  HEX_BLANK     7'h7F  reset/blank value of each HEXn register (segments active-low)
// PORTS
//  Clock        in   1   system clock, all state on rising edge
//  Reset        in   1   asynchronous, active-high reset
//  DataAddr     in   16  processor data address, held stable while DataWaitreq=1
//  DataOut      in   16  processor write data
//  WriteData    in   1   processor write strobe
//  ReadData     in   1   processor read strobe
//  DataIn       out  16  read data to processor, valid when DataWaitreq=0 in DONE
//  DataWaitreq  out  1   stall request to processor
//  mem_addr     out  12  RAM address (=DataAddr[11:0], combinational)
//  mem_wdata    out  16  RAM write data (=DataOut)
//  mem_we       out  1   RAM write enable
//  mem_rdata    in   16  RAM read data
//  SW           in   10  board switches (asynchronous)
//  KEY          in   4   board keys (asynchronous, active-low)
//  LEDR         out  10  LED register
//  HEX0..HEX5   out  7   each, seven-segment registers
// BEHAVIOUR
//  Address map: 0x0000-0x0FFF RAM; 0x1000 LEDR (R/W, low 10 bits); 0x2000+n HEXn, n=0..5 (W, low 7 bits);
//   0x3000 SW (R); 0x3001 KEY (R). Reads of unmapped addresses return 16'h0000; writes to them are dropped.
//   Narrow register reads are zero-extended.
//  Reset values: DataIn=0, DataWaitreq=0, LEDR=0, HEXn=HEX_BLANK, FSM=IDLE, sync flops=0.
//   While Reset=1, DataWaitreq=0.
//  Write: in IDLE with WriteData=1, the write commits at that rising edge.
//   mem_we=WriteData & RAM-hit & IDLE (combinational). DataWaitreq stays 0.
//  WriteData=1 and ReadData=1 in the same cycle: the write wins, the read is ignored, DataWaitreq=0.
//  Read FSM:
//   IDLE: on ReadData=1 & WriteData=0, DataWaitreq=1 (combinational); next state WAIT, cnt<=READ_LATENCY-1.
//   WAIT: DataWaitreq=1. When cnt!=0, cnt decrements.
//     When cnt==0, rdata_q<=selected source (mem_rdata / LEDR / SW_sync / KEY_sync / 0); next state DONE.
//   DONE: DataWaitreq=0, DataIn=rdata_q; next state IDLE unconditionally.
//     ReadData still high in the following IDLE cycle is a NEW request.
//  Latency: request at cycle N -> DataWaitreq high for cycles N..N+READ_LATENCY -> data valid at N+READ_LATENCY+1.
//   This is 2 cycles for READ_LATENCY=1. MMIO reads take the same path and the same latency.
//  DataIn holds its last value outside DONE (no glitch to 0).
//  WriteData asserted in WAIT/DONE is a protocol violation: the write is ignored and a simulation assertion fires.
//  Reset mid-read: FSM returns to IDLE immediately and pending data is discarded; LEDR/HEX are re-initialised.
//  SW and KEY pass through 2-flop synchronisers; reads return the synchronised raw value (KEY stays active-low).
// STRUCTURE
//  bus_pkg: address-map constants (RAM_BASE, LEDR_ADDR, HEX_BASE, SW_ADDR, KEY_ADDR),
//   typedef enum {IDLE, WAIT, DONE} bridge_state_t, and the read-source select enum.
//  Sub-module sync2 (parameterised width, 2-flop, async reset) for SW and KEY.
//  The FSM, address decoder and register file live in this module.
// TESTING
//  1. RAM write 0x0042<-0xBEEF, then read 0x0042, READ_LATENCY=1:
//     DataWaitreq=1 for 2 cycles, DataIn=0xBEEF in the 3rd cycle.
//  2. Write 0x1000<-0x03FF, then read 0x1000: LEDR=10'h3FF and the read returns 0x03FF.
//     Write 0x2003<-0x0040: HEX3=7'h40, other HEXn unchanged.
//  3. SW=10'h155 applied, read 0x3000 after 3 cycles -> 0x0155. KEY=4'b1110, read 0x3001 -> 0x000E.
//  4. Read 0x5000 -> 0x0000 after normal latency. Write 0x5000 -> no RAM write, LEDR/HEX unchanged.
//  5. Back-to-back reads with ReadData held high across DONE:
//     two distinct requests complete, with DataWaitreq toggling 1,1,0,1,1,0.
//  6. Assert Reset during WAIT: DataWaitreq=0 and HEXn=7'h7F at once; the next read completes normally.
//     Repeat 1 with READ_LATENCY=3 -> 4 wait cycles.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data bus bridge: address map, FSM states and read-source select.
package bus_pkg;

   localparam logic [15:0] RAM_BASE  = 16'h0000;
   localparam logic [15:0] LEDR_ADDR = 16'h1000;
   localparam logic [15:0] HEX_BASE  = 16'h2000;
   localparam int          HEX_COUNT = 6;
   localparam logic [15:0] SW_ADDR   = 16'h3000;
   localparam logic [15:0] KEY_ADDR  = 16'h3001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } bridge_state_t;

   typedef enum logic [2:0] {
      SRC_ZERO,
      SRC_RAM,
      SRC_LEDR,
      SRC_SW,
      SRC_KEY
   } read_src_t;

   // HEX registers are write-only, so they fall through to SRC_ZERO like unmapped space.
   function automatic read_src_t decodeReadSource(input logic [15:0] addr);
      if (addr[15:12] == RAM_BASE[15:12]) begin
         return SRC_RAM;
      end
      if (addr == LEDR_ADDR) begin
         return SRC_LEDR;
      end
      if (addr == SW_ADDR) begin
         return SRC_SW;
      end
      if (addr == KEY_ADDR) begin
         return SRC_KEY;
      end
      return SRC_ZERO;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous board inputs; both stages clear on reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/data_bus_bridge.sv
// Data-side bus bridge: maps the processor data port onto a synchronous RAM and board I/O,
// stalling reads until the selected source has been captured.
module data_bus_bridge
   import bus_pkg::*;
#(
   parameter int         READ_LATENCY = 1,
   parameter logic [6:0] HEX_BLANK    = 7'h7F
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] DataAddr,
   input  logic [15:0] DataOut,
   input  logic        WriteData,
   input  logic        ReadData,
   output logic [15:0] DataIn,
   output logic        DataWaitreq,
   output logic [11:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   input  logic [9:0]  SW,
   input  logic [3:0]  KEY,
   output logic [9:0]  LEDR,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5
);

   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   bridge_state_t r_state;
   bridge_state_t w_stateNext;
   logic [1:0]    r_cnt;
   logic [1:0]    w_cntNext;
   logic [15:0]   r_rdata;
   logic [15:0]   w_rdataNext;
   logic [15:0]   w_srcData;
   logic          w_waitreq;
   logic [9:0]    r_ledr;
   logic [6:0]    r_hex [HEX_COUNT];
   logic [9:0]    w_swSync;
   logic [3:0]    w_keySync;
   logic          w_ramHit;
   logic          w_hexHit;
   logic          w_writeCommit;
   read_src_t     w_readSrc;

   sync2 #(.WIDTH(10)) u_swSync (
      .i_clk (Clock),
      .i_rst (Reset),
      .i_d   (SW),
      .o_q   (w_swSync)
   );

   sync2 #(.WIDTH(4)) u_keySync (
      .i_clk (Clock),
      .i_rst (Reset),
      .i_d   (KEY),
      .o_q   (w_keySync)
   );

   assign w_ramHit      = (DataAddr[15:12] == RAM_BASE[15:12]);
   assign w_hexHit      = (DataAddr >= HEX_BASE) && (DataAddr < (HEX_BASE + 16'(HEX_COUNT)));
   assign w_readSrc     = decodeReadSource(DataAddr);
   assign w_writeCommit = WriteData && (r_state == IDLE);

   assign mem_addr  = DataAddr[11:0];
   assign mem_wdata = DataOut;
   assign mem_we    = w_writeCommit && w_ramHit;

   always_comb begin
      w_srcData = 16'h0000;
      unique case (w_readSrc)
         SRC_RAM:  w_srcData = mem_rdata;
         SRC_LEDR: w_srcData = {6'b0, r_ledr};
         SRC_SW:   w_srcData = {6'b0, w_swSync};
         SRC_KEY:  w_srcData = {12'b0, w_keySync};
         default:  w_srcData = 16'h0000;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
         r_rdata <= 16'h0000;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_rdata <= w_rdataNext;
      end
   end

   // A simultaneous write suppresses the read so the write can complete without a stall.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_rdataNext = r_rdata;
      w_waitreq   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (ReadData && !WriteData) begin
               w_waitreq   = 1'b1;
               w_stateNext = WAIT;
               w_cntNext   = CNT_INIT;
            end
         end
         WAIT: begin
            w_waitreq = 1'b1;
            if (r_cnt != 2'd0) begin
               w_cntNext = r_cnt - 2'd1;
            end else begin
               w_rdataNext = w_srcData;
               w_stateNext = DONE;
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign DataWaitreq = w_waitreq && !Reset;
   assign DataIn      = r_rdata;

   // HEX_BASE is aligned, so the low address bits index the digit directly.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_ledr <= 10'h000;
         for (int i = 0; i < HEX_COUNT; i++) begin
            r_hex[i] <= HEX_BLANK;
         end
      end else if (w_writeCommit) begin
         if (DataAddr == LEDR_ADDR) begin
            r_ledr <= DataOut[9:0];
         end
         for (int i = 0; i < HEX_COUNT; i++) begin
            if (w_hexHit && (DataAddr[2:0] == 3'(i))) begin
               r_hex[i] <= DataOut[6:0];
            end
         end
      end
   end

   assign LEDR = r_ledr;
   assign HEX0 = r_hex[0];
   assign HEX1 = r_hex[1];
   assign HEX2 = r_hex[2];
   assign HEX3 = r_hex[3];
   assign HEX4 = r_hex[4];
   assign HEX5 = r_hex[5];

   a_noWriteWhileBusy: assert property (
      @(posedge Clock) disable iff (Reset) !(WriteData && (r_state != IDLE))
   );

endmodule

// File: tb/tb_data_bus_bridge.sv
// Self-checking bench for data_bus_bridge: table vectors, hand-built corner sequences and
// randomized traffic against a behavioural model; a second instance covers READ_LATENCY=3.
module tb_data_bus_bridge;

   typedef struct {
      logic        isWrite;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] expData;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] addr;
   logic [15:0] dout;
   logic wr;
   logic rd;
   logic sel;
   logic [9:0] sw;
   logic [3:0] key;

   logic [15:0] dataIn1, dataIn3, memWdata1, memWdata3, memRdata;
   logic wait1, wait3, memWe1, memWe3;
   logic [11:0] memAddr1, memAddr3;
   logic [9:0] ledr1, ledr3;
   logic [5:0][6:0] hex1, hex3;

   logic [15:0] dataIn, memWdata;
   logic waitreq, memWe;
   logic [11:0] memAddr;
   logic [9:0] ledr;
   logic [5:0][6:0] hexOut;

   logic [15:0] ram [4096] = '{default: 16'h0000};
   logic [15:0] pipe [3];

   logic [15:0] refMem [int];
   logic [9:0]  refLedr;
   logic [6:0]  refHex [6];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign dataIn   = sel ? dataIn3 : dataIn1;
   assign waitreq  = sel ? wait3 : wait1;
   assign memWe    = sel ? memWe3 : memWe1;
   assign memAddr  = sel ? memAddr3 : memAddr1;
   assign memWdata = sel ? memWdata3 : memWdata1;
   assign ledr     = sel ? ledr3 : ledr1;
   assign hexOut   = sel ? hex3 : hex1;

   data_bus_bridge #(.READ_LATENCY(1), .HEX_BLANK(7'h7F)) dut1 (
      .Clock(clk), .Reset(rst), .DataAddr(addr), .DataOut(dout),
      .WriteData(wr & ~sel), .ReadData(rd & ~sel),
      .DataIn(dataIn1), .DataWaitreq(wait1),
      .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_we(memWe1), .mem_rdata(memRdata),
      .SW(sw), .KEY(key), .LEDR(ledr1),
      .HEX0(hex1[0]), .HEX1(hex1[1]), .HEX2(hex1[2]),
      .HEX3(hex1[3]), .HEX4(hex1[4]), .HEX5(hex1[5])
   );

   data_bus_bridge #(.READ_LATENCY(3), .HEX_BLANK(7'h7F)) dut3 (
      .Clock(clk), .Reset(rst), .DataAddr(addr), .DataOut(dout),
      .WriteData(wr & sel), .ReadData(rd & sel),
      .DataIn(dataIn3), .DataWaitreq(wait3),
      .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_we(memWe3), .mem_rdata(memRdata),
      .SW(sw), .KEY(key), .LEDR(ledr3),
      .HEX0(hex3[0]), .HEX1(hex3[1]), .HEX2(hex3[2]),
      .HEX3(hex3[3]), .HEX4(hex3[4]), .HEX5(hex3[5])
   );

   // Synchronous RAM with a read pipeline deep enough for either instance's latency.
   always @(posedge clk) begin
      if (memWe) ram[memAddr] <= memWdata;
      pipe[0] <= ram[memAddr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   assign memRdata = sel ? pipe[2] : pipe[0];

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      refLedr = 10'h000;
      for (int i = 0; i < 6; i++) refHex[i] = 7'h7F;
   endtask

   task automatic modelWrite(input logic [15:0] a, input logic [15:0] d);
      if (a < 16'h1000) refMem[int'(a)] = d;
      else if (a == 16'h1000) refLedr = d[9:0];
      else if (a >= 16'h2000 && a <= 16'h2005) refHex[int'(a - 16'h2000)] = d[6:0];
   endtask

   function automatic logic [15:0] refRead(input logic [15:0] a);
      if (a < 16'h1000) return refMem.exists(int'(a)) ? refMem[int'(a)] : 16'h0000;
      if (a == 16'h1000) return {6'b0, refLedr};
      if (a == 16'h3000) return {6'b0, sw};
      if (a == 16'h3001) return {12'b0, key};
      return 16'h0000;
   endfunction

   task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      addr = a; dout = d; wr = 1'b1; rd = 1'b0;
      #1;
      checkOutput("wr_waitreq", 32'(waitreq), 32'd0);
      checkOutput("wr_mem_we", 32'(memWe), 32'(a < 16'h1000));
      @(negedge clk);
      wr = 1'b0;
   endtask

   // Counts cycles with DataWaitreq high, then returns DataIn from the DONE cycle.
   task automatic busRead(input logic [15:0] a, output logic [15:0] data, output int waits);
      @(negedge clk);
      addr = a; rd = 1'b1; wr = 1'b0; waits = 0;
      #1;
      while (waitreq === 1'b1 && waits < 20) begin
         waits++;
         @(negedge clk);
         #1;
      end
      data = dataIn;
      rd = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [15:0] got;
      int waits;
      if (v.isWrite) begin
         busWrite(v.addr, v.data);
         modelWrite(v.addr, v.data);
      end else begin
         busRead(v.addr, got, waits);
         checkOutput($sformatf("vec%0d_data", idx), 32'(got), 32'(v.expData));
         checkOutput($sformatf("vec%0d_waits", idx), 32'(waits), 32'd2);
      end
   endtask

   initial begin
      vec_t vecs [17];
      logic [6:0] expHex [6];
      logic expW [6];
      logic [15:0] a, d, got;
      int waits, kind;

      vecs = '{
         '{1'b1, 16'h0042, 16'hBEEF, 16'h0000},
         '{1'b0, 16'h0042, 16'h0000, 16'hBEEF},
         '{1'b1, 16'h1000, 16'h03FF, 16'h0000},
         '{1'b0, 16'h1000, 16'h0000, 16'h03FF},
         '{1'b1, 16'h2003, 16'h0040, 16'h0000},
         '{1'b0, 16'h3000, 16'h0000, 16'h0155},
         '{1'b0, 16'h3001, 16'h0000, 16'h000E},
         '{1'b0, 16'h5000, 16'h0000, 16'h0000},
         '{1'b1, 16'h5000, 16'h1234, 16'h0000},
         '{1'b0, 16'h0000, 16'h0000, 16'h0000},
         '{1'b1, 16'h0FFF, 16'hA5A5, 16'h0000},
         '{1'b0, 16'h0FFF, 16'h0000, 16'hA5A5},
         '{1'b1, 16'h1000, 16'hFFFF, 16'h0000},
         '{1'b0, 16'h1000, 16'h0000, 16'h03FF},
         '{1'b1, 16'h2005, 16'h0012, 16'h0000},
         '{1'b1, 16'h2006, 16'h0055, 16'h0000},
         '{1'b0, 16'h1001, 16'h0000, 16'h0000}
      };
      expHex = '{7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h12};
      expW   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      sel = 1'b0; rst = 1'b1; wr = 1'b0; rd = 1'b1;
      addr = 16'h0042; dout = 16'h0000;
      sw = 10'h155; key = 4'b1110;
      modelReset();

      // Reset state, with a read strobe already asserted.
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_waitreq_held", 32'(waitreq), 32'd0);
      checkOutput("rst_datain", 32'(dataIn), 32'd0);
      checkOutput("rst_ledr", 32'(ledr), 32'd0);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("rst_hex%0d", i), 32'(hexOut[i]), 32'h7F);
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);
      checkOutput("tbl_ledr", 32'(ledr), 32'h3FF);
      for (int i = 0; i < 6; i++) checkOutput($sformatf("tbl_hex%0d", i), 32'(hexOut[i]), 32'(expHex[i]));

      // Write and read together: the write wins and no stall appears.
      @(negedge clk);
      addr = 16'h1000; dout = 16'h0155; wr = 1'b1; rd = 1'b1;
      #1;
      checkOutput("wrrd_waitreq", 32'(waitreq), 32'd0);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      #1;
      checkOutput("wrrd_waitreq_next", 32'(waitreq), 32'd0);
      checkOutput("wrrd_ledr", 32'(ledr), 32'h155);
      modelWrite(16'h1000, 16'h0155);

      // DataIn keeps the last read value while idle.
      busRead(16'h0FFF, got, waits);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("hold_datain", 32'(dataIn), 32'hA5A5);

      // Back-to-back reads with ReadData held across DONE.
      @(negedge clk);
      addr = 16'h0042; rd = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         checkOutput($sformatf("b2b_wait%0d", c), 32'(waitreq), 32'(expW[c]));
         if (c == 2) begin
            checkOutput("b2b_data0", 32'(dataIn), 32'hBEEF);
            addr = 16'h1000;
         end
         if (c == 5) checkOutput("b2b_data1", 32'(dataIn), 32'h0155);
         @(negedge clk);
      end
      rd = 1'b0;

      // Reset in the middle of a read.
      busWrite(16'h2001, 16'h0011);
      modelWrite(16'h2001, 16'h0011);
      @(negedge clk);
      addr = 16'h0042; rd = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("mid_wait_before_rst", 32'(waitreq), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_waitreq", 32'(waitreq), 32'd0);
      checkOutput("mid_rst_hex1", 32'(hexOut[1]), 32'h7F);
      checkOutput("mid_rst_ledr", 32'(ledr), 32'd0);
      checkOutput("mid_rst_datain", 32'(dataIn), 32'd0);
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      busRead(16'h0042, got, waits);
      checkOutput("post_rst_data", 32'(got), 32'hBEEF);
      checkOutput("post_rst_waits", 32'(waits), 32'd2);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 150; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 9) begin
            sw = 10'($urandom);
            key = 4'($urandom);
            repeat (3) @(negedge clk);
            continue;
         end
         case ($urandom_range(0, 5))
            0, 1: begin
               a = 16'($urandom_range(0, 31));
               if (a > 16'd15) a = 16'h0FE0 + a;
            end
            2: a = 16'h1000;
            3: a = 16'h2000 + 16'($urandom_range(0, 7));
            4: a = ($urandom_range(0, 1) == 0) ? 16'h3000 : 16'h3001;
            default: a = 16'($urandom);
         endcase
         d = 16'($urandom);
         if (kind < 4) begin
            busWrite(a, d);
            modelWrite(a, d);
         end else begin
            busRead(a, got, waits);
            checkOutput($sformatf("rnd%0d_read@%0h", n, a), 32'(got), 32'(refRead(a)));
            checkOutput($sformatf("rnd%0d_waits", n), 32'(waits), 32'd2);
         end
      end
      checkOutput("rnd_ledr", 32'(ledr), 32'(refLedr));
      for (int i = 0; i < 6; i++) checkOutput($sformatf("rnd_hex%0d", i), 32'(hexOut[i]), 32'(refHex[i]));

      // READ_LATENCY=3 instance.
      sel = 1'b1;
      sw = 10'h155;
      repeat (3) @(negedge clk);
      busWrite(16'h0042, 16'hBEEF);
      busRead(16'h0042, got, waits);
      checkOutput("rl3_data", 32'(got), 32'hBEEF);
      checkOutput("rl3_waits", 32'(waits), 32'd4);
      busRead(16'h3000, got, waits);
      checkOutput("rl3_sw_data", 32'(got), 32'h0155);
      checkOutput("rl3_sw_waits", 32'(waits), 32'd4);
      busWrite(16'h1000, 16'h02AA);
      #1;
      checkOutput("rl3_ledr", 32'(ledr), 32'h2AA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
